// File: rtl/writeback_unit.sv
// Final pipeline stage: buffers completed results in a small FIFO and drives the
// register-file write port, pending-destination mask and retired-write counter.
module writeback_unit #(
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic             in_sel,
    input  logic [3:0]       in_dest,
    input  logic [DW-1:0]    in_alu,
    input  logic [DW-1:0]    in_mem,
    input  logic [DW-1:0]    in_r0,
    input  logic             wb_hold,
    input  logic             flush,
    output logic [1:0]       reg_write,
    output logic [3:0]       wb_dest,
    output logic [DW-1:0]    wb_data,
    output logic [DW-1:0]    wb_r0,
    output logic [15:0]      pending_mask,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             err_illegal
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t          state, state_nxt;
    logic [AW:0]     count, count_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr, idx;
    logic [1:0]      kind_q [DEPTH];
    logic [3:0]      dest_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   r0_q   [DEPTH];
    logic            hs, push, pop;

    assign in_ready = reset & ~flush & (state != FULL);
    assign hs       = in_valid & in_ready;
    // Kinds 0 and 3 complete the handshake but never occupy an entry.
    assign push     = hs & ((in_kind == 2'd1) | (in_kind == 2'd2));
    assign pop      = reset & ~wb_hold & ~flush & (state != EMPTY);

    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
        end
        if (count_nxt == '0) begin
            state_nxt = EMPTY;
        end else if (count_nxt == (AW+1)'(DEPTH)) begin
            state_nxt = FULL;
        end else begin
            state_nxt = PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= EMPTY;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            reg_write   <= '0;
            wb_dest     <= '0;
            wb_data     <= '0;
            wb_r0       <= '0;
            retired_cnt <= '0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) begin
                kind_q[wr_ptr] <= in_kind;
                dest_q[wr_ptr] <= in_dest;
                data_q[wr_ptr] <= in_sel ? in_mem : in_alu;
                r0_q[wr_ptr]   <= in_r0;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) begin
                reg_write   <= kind_q[rd_ptr];
                wb_dest     <= dest_q[rd_ptr];
                wb_data     <= data_q[rd_ptr];
                wb_r0       <= r0_q[rd_ptr];
                rd_ptr      <= rd_ptr + AW'(1);
                retired_cnt <= retired_cnt + CNT_W'(1);
            end else begin
                reg_write <= '0;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
            if (hs && in_kind == 2'd3) begin
                err_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        idx          = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((AW+1)'(i) < count) begin
                pending_mask[dest_q[idx]] = 1'b1;
                if (kind_q[idx] == 2'd2) begin
                    pending_mask[0] = 1'b1;
                end
            end
        end
        if (reg_write != 2'd0) begin
            pending_mask[wb_dest] = 1'b1;
            if (reg_write == 2'd2) begin
                pending_mask[0] = 1'b1;
            end
        end
    end

endmodule
